dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter for the single-port data RAM, with memory-mapped decode of the random-number source. Sits between the processor's data-memory port (master 0) and the RAM/`lsfr` pair. A second master (master 1: debug loader, display fetch or test harness) shares the same 12-bit RAM. Grants one access per cycle, round-robin, and returns read data one cycle after grant.

## Interface
Parameters:
- `ADDR_W`, 12, address width (RAM is 4096 x 32).
- `DATA_W`, 32, data width.
- `RNG_ADDR`, 99, word address that maps to the random-number source.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `m0_req`  in  1  master 0 requests an access; held until granted.
- `m0_we`  in  1  1 = write, 0 = read.
- `m0_addr`  in  ADDR_W  word address.
- `m0_wdata`  in  DATA_W  write data.
- `m0_gnt`  out  1  access accepted this cycle.
- `m0_rvalid`  out  1  read data valid.
- `m0_rdata`  out  DATA_W  read data.
- `m1_*`  same seven signals for master 1.
- `ram_wEn`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_dataIn`  out  DATA_W  RAM write data.
- `ram_dataOut`  in  DATA_W  RAM read data, valid the cycle after the address edge.
- `rng_in`  in  DATA_W  current `lsfr` output.

## Operation
- Arbitration is combinational in the request cycle.
  - Only one `mN_req`: that master wins.
  - Both requesting: the master other than `last_gnt` wins.
  - Neither requesting: no grant; `ram_wEn`=0.
- `last_gnt` updates on every grant.
- Winner's `we/addr/wdata` drive the RAM port. `ram_wEn` = winner's `we`, except writes to `RNG_ADDR`: those are granted but dropped (`ram_wEn`=0).
- Read grant registers the response stage: `rv_id` (winner), `rv_rng` (addr==`RNG_ADDR`), `rng_q` <= `rng_in`, `rv_valid`<=1.
- Response cycle:
  - `mN_rvalid`=1 only for N==`rv_id`.
  - `rdata` = `rv_rng` ? `rng_q` : `ram_dataOut`.
  - Non-selected master's `rdata` = 0.
- Write grants produce no `rvalid`.
- Back-to-back grants allowed: a new grant and the previous read's `rvalid` coexist in one cycle.
- Loser keeps `req` asserted with stable `we/addr/wdata`. Changing them before grant is illegal; it is checked by assertion only.
- Reset:
  - `last_gnt`=1, so master 0 wins the first contended cycle.
  - `rv_valid`=0, `rv_id`=0, `rv_rng`=0, `rng_q`=0.
  - A read granted in the cycle reset is high never produces `rvalid`.
- All outputs are 0 during reset except the combinational `gnt`/RAM drive, which are forced to 0 while `reset`=1.

## Timing
- Grant latency: 0 cycles, same cycle as `req` when uncontended.
- Contended: loser granted the next cycle at the latest.
- Write commits at the grant edge.
- Read latency: `rvalid` exactly 1 cycle after `gnt`.
- Throughput: 1 access/cycle total. With both masters continuously requesting, grants strictly alternate.
- `RNG_ADDR` read returns `rng_in` sampled at the grant edge, not the value in the response cycle.

## Configuration
- `DMEM_ARB_RNG_EN` defined: `RNG_ADDR` decode active as above.
- Undefined:
  - `RNG_ADDR` is ordinary RAM (reads return `ram_dataOut`, writes commit).
  - `rng_in` is unused; `rng_q`/`rv_rng` are not built.

## Structure
- Package `dmem_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults and `RNG_ADDR`.
  - Master-id typedef (`M_CPU`=0, `M_AUX`=1).
  - Response-stage struct `{valid, id, rng}`.
- One sub-module `rr_arb2`: 2-way round-robin picker. Inputs: `req[1:0]`, `last_gnt`. Output: one-hot `gnt[1:0]`. Purely combinational; `last_gnt` is registered in the parent.

## Test plan
- Reset, then single m0 read of addr 5 (RAM[5]=0x1234) -> `m0_gnt` same cycle, `m0_rvalid`=1 with 0x1234 next cycle, `m1_rvalid`=0.
- Both masters request continuously for 6 cycles after reset (m0 write addr 10, m1 write addr 11) -> grant order m0,m1,m0,m1,m0,m1; RAM[10]/RAM[11] hold the last written values.
- m0 read addr 99 with `rng_in`=0xDEADBEEF at the grant edge, changing to 0x1 next cycle -> `m0_rdata`=0xDEADBEEF. With macro undefined -> returns RAM[99].
- m1 write 0x55 to addr 99 (macro on) -> `m1_gnt`=1, `ram_wEn`=0, subsequent RAM[99] unchanged.
- Back-to-back m0 reads addr 1,2,3 (values 7,8,9) -> `rvalid` on three consecutive cycles carrying 7,8,9.
- Assert `reset` in the cycle after an m1 read grant -> no `m1_rvalid`. Post-reset contended request -> m0 wins.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the two-master data-RAM arbiter.
// Holds bus widths, the RNG word address, master ids and the response-stage record.
package dmem_pkg;

  localparam int unsigned ADDR_W_DEF   = 12;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned RNG_ADDR_DEF = 99;

  typedef enum logic {
    M_CPU = 1'b0,
    M_AUX = 1'b1
  } master_id_e;

  typedef struct packed {
    logic       valid;
    master_id_e id;
    logic       rng;
  } rsp_t;

  localparam rsp_t RSP_RESET = '{valid: 1'b0, id: M_CPU, rng: 1'b0};

  function automatic master_id_e onehot_to_id(input logic [1:0] gnt);
    return gnt[1] ? M_AUX : M_CPU;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One master's request/response channel into the data-RAM arbiter.
// The arbiter takes the slave side; the requesting agent takes the master side.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter_chk.sv
// Protocol checker for one master channel: a waiting requester must keep
// req asserted with unchanged we/addr/wdata until it is granted.
module dmem_arbiter_chk #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input logic              clock,
  input logic              reset,
  input logic              req,
  input logic              gnt,
  input logic              we,
  input logic [ADDR_W-1:0] addr,
  input logic [DATA_W-1:0] wdata
);

  property p_hold_until_gnt;
    @(posedge clock) disable iff (reset)
      (req && !gnt) |=> (req && $stable(we) && $stable(addr) && $stable(wdata));
  endproperty

  a_hold_until_gnt: assert property (p_hold_until_gnt)
    else $error("dmem_arbiter_chk: request dropped or changed before grant");

endmodule

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// master that was not granted last. Purely combinational.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_e last_gnt,
  output logic [1:0] gnt
);

  // Pick the winner for this cycle
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == M_AUX) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the single-port data RAM with read data
// one cycle after grant. Define DMEM_ARB_RNG_EN to map RNG_ADDR onto rng_in.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RNG_ADDR = RNG_ADDR_DEF
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut,
  input  logic [DATA_W-1:0] rng_in
);

  logic [1:0]        req_s;
  logic [1:0]        arb_gnt_s;
  logic [1:0]        gnt_s;
  master_id_e        win_id_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;
  logic              rng_hit_s;
  logic              rd_gnt_s;
  logic [1:0]        rv_s;
  logic [DATA_W-1:0] rsp_data_s;

  master_id_e last_gnt_q, last_gnt_d;
  rsp_t       rsp_q, rsp_d;

  assign req_s = {m1.req, m0.req};

  rr_arb2 u_arb (
    .req      (req_s),
    .last_gnt (last_gnt_q),
    .gnt      (arb_gnt_s)
  );

  // Gate the grant with reset and steer the winner onto the RAM port
  always_comb begin
    gnt_s       = 2'b00;
    win_we_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    if (reset) begin
      gnt_s = 2'b00;
    end else begin
      gnt_s = arb_gnt_s;
    end
    case (gnt_s)
      2'b01: begin
        win_we_s    = m0.we;
        win_addr_s  = m0.addr;
        win_wdata_s = m0.wdata;
      end
      2'b10: begin
        win_we_s    = m1.we;
        win_addr_s  = m1.addr;
        win_wdata_s = m1.wdata;
      end
      default: begin
        win_we_s    = 1'b0;
        win_addr_s  = '0;
        win_wdata_s = '0;
      end
    endcase
  end

  assign win_id_s = onehot_to_id(gnt_s);
  assign rd_gnt_s = (|gnt_s) & ~win_we_s;

`ifdef DMEM_ARB_RNG_EN
  localparam logic [ADDR_W-1:0] RNG_A = ADDR_W'(RNG_ADDR);
  logic [DATA_W-1:0] rng_q;

  assign rng_hit_s = (win_addr_s == RNG_A);

  // Capture the RNG value at the read-grant edge, not in the response cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      rng_q <= '0;
    end else if (rd_gnt_s) begin
      rng_q <= rng_in;
    end else begin
      rng_q <= rng_q;
    end
  end

  assign rsp_data_s = rsp_q.rng ? rng_q : ram_dataOut;
`else
  logic unused_rng_s;

  assign rng_hit_s    = 1'b0;
  assign rsp_data_s   = ram_dataOut;
  assign unused_rng_s = ^{rng_in, ADDR_W'(RNG_ADDR), rsp_q.rng};
`endif

  // Writes to the RNG word are accepted but never reach the RAM
  assign ram_wEn    = win_we_s & ~rng_hit_s;
  assign ram_addr   = win_addr_s;
  assign ram_dataIn = win_wdata_s;

  // Next-state for the round-robin pointer and the response stage
  always_comb begin
    last_gnt_d = last_gnt_q;
    rsp_d      = rsp_q;
    if (|gnt_s) begin
      last_gnt_d = win_id_s;
    end else begin
      last_gnt_d = last_gnt_q;
    end
    if (rd_gnt_s) begin
      rsp_d.valid = 1'b1;
      rsp_d.id    = win_id_s;
      rsp_d.rng   = rng_hit_s;
    end else begin
      rsp_d.valid = 1'b0;
    end
  end

  // State registers; M_AUX as last winner lets master 0 take the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt_q <= M_AUX;
      rsp_q      <= RSP_RESET;
    end else begin
      last_gnt_q <= last_gnt_d;
      rsp_q      <= rsp_d;
    end
  end

  assign rv_s[0] = ~reset & rsp_q.valid & (rsp_q.id == M_CPU);
  assign rv_s[1] = ~reset & rsp_q.valid & (rsp_q.id == M_AUX);

  assign m0.gnt    = gnt_s[0];
  assign m1.gnt    = gnt_s[1];
  assign m0.rvalid = rv_s[0];
  assign m1.rvalid = rv_s[1];
  assign m0.rdata  = rv_s[0] ? rsp_data_s : '0;
  assign m1.rdata  = rv_s[1] ? rsp_data_s : '0;

  dmem_arbiter_chk #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk_m0 (
    .clock (clock),
    .reset (reset),
    .req   (m0.req),
    .gnt   (gnt_s[0]),
    .we    (m0.we),
    .addr  (m0.addr),
    .wdata (m0.wdata)
  );

  dmem_arbiter_chk #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk_m1 (
    .clock (clock),
    .reset (reset),
    .req   (m1.req),
    .gnt   (gnt_s[1]),
    .we    (m1.we),
    .addr  (m1.addr),
    .wdata (m1.wdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a RAM model and a
// read-response scoreboard; follows DMEM_ARB_RNG_EN if it is defined.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RNG_EN
  localparam bit RNG_ON = 1'b1;
`else
  localparam bit RNG_ON = 1'b0;
`endif

  typedef struct {
    bit          id;
    logic [31:0] data;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        preload;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut;
  logic [31:0] rng_in;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  exp_t        exp_q[$];
  int          checks;
  int          errors;

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) m0_if ();
  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) m1_if ();

  dmem_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .ram_wEn     (ram_wEn),
    .ram_addr    (ram_addr),
    .ram_dataIn  (ram_dataIn),
    .ram_dataOut (ram_dataOut),
    .rng_in      (rng_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] init_val(input logic [11:0] a);
    case (a)
      12'd1:   return 32'd7;
      12'd2:   return 32'd8;
      12'd3:   return 32'd9;
      12'd5:   return 32'h0000_1234;
      default: return {20'hC0DE0, a};
    endcase
  endfunction

  // Single-port RAM model: synchronous write, read data one cycle after address
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(12'(i));
    end else if (ram_wEn) begin
      mem[ram_addr] <= ram_dataIn;
    end
    ram_dataOut <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit m, input logic req, input logic we,
                       input logic [11:0] addr, input logic [31:0] wdata);
    if (m == 1'b0) begin
      m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
    end
  endtask

  task automatic record(input bit id, input logic we, input logic [11:0] addr,
                        input logic [31:0] wdata);
    bit hit;
    hit = RNG_ON && (addr == 12'd99);
    if (we) begin
      if (!hit) ref_mem[addr] = wdata;
    end else begin
      exp_q.push_back('{id: id, data: (hit ? rng_in : ref_mem[addr])});
    end
  endtask

  // Settle after the input change, compare responses, log this cycle's grants
  task automatic settle();
    exp_t e;
    #1;
    if (reset) begin
      exp_q.delete();
      chk("rst_rvalid0", {31'd0, m0_if.rvalid}, 32'd0);
      chk("rst_rvalid1", {31'd0, m1_if.rvalid}, 32'd0);
      chk("rst_gnt", {30'd0, m1_if.gnt, m0_if.gnt}, 32'd0);
      chk("rst_wen", {31'd0, ram_wEn}, 32'd0);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_rvalid0", {31'd0, m0_if.rvalid}, {31'd0, e.id == 1'b0});
        chk("sb_rvalid1", {31'd0, m1_if.rvalid}, {31'd0, e.id == 1'b1});
        chk("sb_rdata0", m0_if.rdata, (e.id == 1'b0) ? e.data : 32'd0);
        chk("sb_rdata1", m1_if.rdata, (e.id == 1'b1) ? e.data : 32'd0);
      end else begin
        chk("sb_idle_rv", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
      end
      if (m0_if.gnt) record(1'b0, m0_if.we, m0_if.addr, m0_if.wdata);
      if (m1_if.gnt) record(1'b1, m1_if.we, m1_if.addr, m1_if.wdata);
    end
  endtask

  task automatic next();
    @(negedge clock);
  endtask

  initial begin
    int c0;
    int c1;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    reset = 1'b1; preload = 1'b1; rng_in = 32'd0;
    drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
    next();
    preload = 1'b0;

    // Request during reset is not granted; single read once reset drops
    drive(1'b0, 1'b1, 1'b0, 12'd5, 32'd0);
    settle(); chk("rst_ram_addr", {20'd0, ram_addr}, 32'd0); next();
    reset = 1'b0;
    settle();
    chk("t1_gnt0", {31'd0, m0_if.gnt}, 32'd1);
    chk("t1_gnt1", {31'd0, m1_if.gnt}, 32'd0);
    chk("t1_addr", {20'd0, ram_addr}, 32'd5);
    chk("t1_wen", {31'd0, ram_wEn}, 32'd0);
    next();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
    settle();
    chk("t1_rdata", m0_if.rdata, 32'h0000_1234);
    chk("t1_rvalid1", {31'd0, m1_if.rvalid}, 32'd0);
    next();

    // Contended writes right after reset must alternate m0,m1,...
    reset = 1'b1; settle(); next(); reset = 1'b0;
    c0 = 0; c1 = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, c0 < 3, 1'b1, 12'd10, 32'hA0 + 32'(c0));
      drive(1'b1, c1 < 3, 1'b1, 12'd11, 32'hB0 + 32'(c1));
      settle();
      chk("rr_order", {30'd0, m1_if.gnt, m0_if.gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (m0_if.gnt) c0++;
      if (m1_if.gnt) c1++;
      next();
    end
    drive(1'b0, 1'b1, 1'b0, 12'd10, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
    settle(); next();
    drive(1'b0, 1'b1, 1'b0, 12'd11, 32'd0);
    settle(); chk("rr_ram10", m0_if.rdata, 32'hA2); next();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
    settle(); chk("rr_ram11", m0_if.rdata, 32'hB2); next();

    // RNG word read returns the value sampled at the grant edge
    drive(1'b0, 1'b1, 1'b0, 12'd99, 32'd0);
    rng_in = 32'hDEAD_BEEF;
    settle(); chk("rng_gnt", {31'd0, m0_if.gnt}, 32'd1); next();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
    rng_in = 32'h0000_0001;
    settle(); chk("rng_rdata", m0_if.rdata, RNG_ON ? 32'hDEAD_BEEF : init_val(12'd99)); next();

    // Write to the RNG word: granted, dropped when decode is active
    drive(1'b1, 1'b1, 1'b1, 12'd99, 32'h55);
    settle();
    chk("rngw_gnt", {31'd0, m1_if.gnt}, 32'd1);
    chk("rngw_wen", {31'd0, ram_wEn}, RNG_ON ? 32'd0 : 32'd1);
    next();
    drive(1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
    settle(); next();
    chk("rngw_ram99", mem[99], RNG_ON ? init_val(12'd99) : 32'h55);
    drive(1'b1, 1'b1, 1'b0, 12'd99, 32'd0);
    rng_in = 32'h0BAD_F00D;
    settle(); next();
    drive(1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
    rng_in = 32'h0000_0002;
    settle(); chk("rngw_rdata", m1_if.rdata, RNG_ON ? 32'h0BAD_F00D : 32'h55); next();

    // Back-to-back reads: rvalid on three consecutive cycles
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b0, 1'b1, 1'b0, 12'(i + 1), 32'd0);
      else       drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
      settle();
      if (i < 3) chk("b2b_gnt", {31'd0, m0_if.gnt}, 32'd1);
      if (i > 0) begin
        chk("b2b_rvalid", {31'd0, m0_if.rvalid}, 32'd1);
        chk("b2b_rdata", m0_if.rdata, 32'(6 + i));
      end
      next();
    end

    // Reset in the response cycle of an m1 read suppresses rvalid
    drive(1'b1, 1'b1, 1'b0, 12'd5, 32'd0);
    settle(); chk("rr_m1_gnt", {31'd0, m1_if.gnt}, 32'd1); next();
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 12'd1, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 12'd2, 32'd0);
    settle(); chk("rst_no_m1_rvalid", {31'd0, m1_if.rvalid}, 32'd0); next();
    reset = 1'b0;
    settle();
    chk("post_rst_gnt0", {31'd0, m0_if.gnt}, 32'd1);
    chk("post_rst_gnt1", {31'd0, m1_if.gnt}, 32'd0);
    next();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0);
    settle();
    chk("post_rst_m1_gnt", {31'd0, m1_if.gnt}, 32'd1);
    chk("post_rst_m0_rdata", m0_if.rdata, 32'd7);
    next();
    drive(1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
    settle(); chk("post_rst_m1_rdata", m1_if.rdata, 32'd8); next();
    settle();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
